// File: rtl/tpu_pkg.sv
// tpu_pkg: shared accumulator geometry and drain engine state encoding
package tpu_pkg;
  localparam int ACC_DATA_W = 64;
  localparam int ACC_ADDR_W = 8;
  localparam int ACC_DEPTH = 256;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_FLUSH,
    ST_DONE
  } drain_state_e;
endpackage

// File: rtl/acc_drain_fifo.sv
// acc_drain_fifo: small synchronous FIFO with occupancy count and sync clear
module acc_drain_fifo #(
  parameter int W = 65,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      push,
  input  logic [W-1:0]              push_data,
  input  logic                      pop,
  output logic [W-1:0]              head,
  output logic                      valid,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign valid = count != '0;
  assign head = valid ? mem[rd_ptr] : '0;
  // storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge clk)
    if (push && !clr) mem[wr_ptr] <= push_data;
  // pointers and occupancy; clear discards everything queued
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + ($clog2(DEPTH)+1)'(push) - ($clog2(DEPTH)+1)'(pop);
    end
endmodule

// File: rtl/acc_drain.sv
// acc_drain: reads an address range of one accumulator buffer and streams it out over valid/ready
module acc_drain
  import tpu_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int ADDR_W = ACC_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              buf_sel,
  input  logic              abort,
  output logic              acc_buf_sel,
  output logic              acc_rd_en,
  output logic [ADDR_W-1:0] acc_rd_addr,
  input  logic [DATA_W-1:0] acc_rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] REM_ONE = 1;
  drain_state_e state;
  logic [ADDR_W:0] remaining, rem_after;
  logic rd_v_q, rd_last_q, push, pop, fifo_valid, credit;
  logic [CW-1:0] fifo_cnt, fifo_nxt;
  logic [DATA_W:0] head;
  // an empty FIFO lets the returning datum go straight out; it is only queued if not taken
  assign push = rd_v_q & (fifo_valid | ~out_ready);
  assign pop = fifo_valid & out_ready;
  assign out_valid = fifo_valid | rd_v_q;
  assign out_data = fifo_valid ? head[DATA_W-1:0] : rd_v_q ? acc_rd_data : '0;
  assign out_last = fifo_valid ? head[DATA_W] : rd_v_q & rd_last_q;
  // next-cycle credit: occupancy then plus the read still returning then must leave a slot
  assign fifo_nxt = fifo_cnt + CW'(push) - CW'(pop);
  assign rem_after = remaining - (ADDR_W+1)'(acc_rd_en);
  assign credit = fifo_nxt + CW'(acc_rd_en) < CW'(FIFO_DEPTH);

  acc_drain_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (abort),
    .push      (push),
    .push_data ({rd_last_q, acc_rd_data}),
    .pop       (pop),
    .head      (head),
    .valid     (fifo_valid),
    .count     (fifo_cnt)
  );

  // command FSM, address generator and read-return tracking, all outputs registered
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      acc_buf_sel <= 1'b0;
      acc_rd_en <= 1'b0;
      acc_rd_addr <= '0;
      remaining <= '0;
      rd_v_q <= 1'b0;
      rd_last_q <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (abort) begin
      state <= ST_IDLE;
      acc_rd_en <= 1'b0;
      rd_v_q <= 1'b0;
      rd_last_q <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      rd_v_q <= acc_rd_en;
      rd_last_q <= acc_rd_en && remaining == REM_ONE;
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          acc_buf_sel <= buf_sel;
          acc_rd_addr <= base_addr;
          remaining <= count;
          busy <= 1'b1;
          done <= count == '0;
          state <= count == '0 ? ST_DONE : ST_SETUP;
        end
        ST_SETUP: begin
          acc_rd_en <= 1'b1;
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (acc_rd_en) acc_rd_addr <= acc_rd_addr + ADDR_W'(1);
          remaining <= rem_after;
          acc_rd_en <= rem_after != '0 && credit;
          if (rem_after == '0) state <= ST_FLUSH;
        end
        ST_FLUSH: if (!rd_v_q && fifo_cnt == '0) begin
          done <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          busy <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_acc_drain.sv
// tb_acc_drain: directed stimulus against a queue-based model of the drain stream
module tb_acc_drain;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int FD = 4;
  logic clk = 0, rst_n = 1, start = 0, buf_sel = 0, abort = 0, out_ready = 0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] count = '0;
  logic acc_buf_sel, acc_rd_en, out_valid, out_last, busy, done;
  logic [AW-1:0] acc_rd_addr;
  logic [DW-1:0] acc_rd_data, out_data;
  int checks = 0, errors = 0;
  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem1 [256];
  logic sel_q = 0;
  logic [DW-1:0] exp_d [$];
  logic exp_l [$];
  logic [AW-1:0] exp_a [$];
  logic exp_s = 0;
  int outstanding = 0, words = 0, dones = 0, reads = 0;
  logic stall_q = 0;
  logic [DW-1:0] prev_d = '0;

  always #5 clk = ~clk;

  acc_drain dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .count       (count),
    .buf_sel     (buf_sel),
    .abort       (abort),
    .acc_buf_sel (acc_buf_sel),
    .acc_rd_en   (acc_rd_en),
    .acc_rd_addr (acc_rd_addr),
    .acc_rd_data (acc_rd_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  function automatic logic [DW-1:0] word(input logic s, input int a);
    return (64'(a) * 64'h1_0000_0001) ^ (s ? 64'hB000_0000_B000_0000 : 64'd0);
  endfunction

  // accumulator model: registered buffer select, one-cycle read latency, junk when idle
  always @(posedge clk) begin
    sel_q <= acc_buf_sel;
    acc_rd_data <= acc_rd_en ? (sel_q ? mem1[acc_rd_addr] : mem0[acc_rd_addr]) : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    exp_a.delete();
    exp_d.delete();
    exp_l.delete();
    outstanding = 0;
  endtask

  task automatic cmd(input logic [AW-1:0] b, input int n, input logic s);
    for (int k = 0; k < n; k++) begin
      exp_a.push_back(AW'(int'(b) + k));
      exp_d.push_back(word(s, (int'(b) + k) % 256));
      exp_l.push_back(k == n - 1);
    end
    exp_s = s;
    base_addr = b;
    count = 9'(n);
    buf_sel = s;
    start = 1;
    tick;
    start = 0;
  endtask

  task automatic wait_idle(input int lim);
    int t;
    t = 0;
    while (busy && t < lim) begin
      tick;
      t++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle still busy after %0d cycles", lim);
    end
  endtask

  // per-cycle comparison of reads and stream against the model queues
  always @(negedge clk) begin
    if (!rst_n) stall_q = 0;
    else begin
      if (acc_rd_en) begin
        reads++;
        outstanding++;
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected addr %h", acc_rd_addr);
        end else begin
          chk("rd_addr", 64'(acc_rd_addr), 64'(exp_a.pop_front()));
          chk("rd_sel", 64'(acc_buf_sel), 64'(exp_s));
        end
        chk("credit_bound", 64'(outstanding > FD), 64'd0);
      end
      if (stall_q) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", out_data, prev_d);
      end
      if (out_valid) begin
        if (exp_d.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected data %h", out_data);
        end else begin
          chk("out_data", out_data, exp_d[0]);
          chk("out_last", 64'(out_last), 64'(exp_l[0]));
          if (out_ready) begin
            void'(exp_d.pop_front());
            void'(exp_l.pop_front());
            outstanding--;
            words++;
          end
        end
      end
      stall_q = out_valid & !out_ready;
      prev_d = out_data;
      if (done) dones++;
    end
  end

  task automatic chk_reset_outputs(input string n);
    chk({n, "_buf_sel"}, 64'(acc_buf_sel), 64'd0);
    chk({n, "_rd_en"}, 64'(acc_rd_en), 64'd0);
    chk({n, "_rd_addr"}, 64'(acc_rd_addr), 64'd0);
    chk({n, "_valid"}, 64'(out_valid), 64'd0);
    chk({n, "_data"}, out_data, 64'd0);
    chk({n, "_last"}, 64'(out_last), 64'd0);
    chk({n, "_busy"}, 64'(busy), 64'd0);
    chk({n, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = word(0, i);
      mem1[i] = word(1, i);
    end
    #2 rst_n = 0;
    tick;
    tick;
    chk_reset_outputs("reset");
    rst_n = 1;
    tick;

    // basic drain with latency pinned by literals
    out_ready = 1;
    dones = 0;
    words = 0;
    cmd(8'h10, 4, 0);
    chk("setup_no_read", 64'(acc_rd_en), 64'd0);
    chk("setup_busy", 64'(busy), 64'd1);
    chk("setup_no_valid", 64'(out_valid), 64'd0);
    tick;
    chk("issue_rd_en", 64'(acc_rd_en), 64'd1);
    chk("issue_addr", 64'(acc_rd_addr), 64'h10);
    chk("issue_no_valid", 64'(out_valid), 64'd0);
    tick;
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_word", out_data, 64'h0000_0010_0000_0010);
    wait_idle(50);
    chk("basic_words", 64'(words), 64'd4);
    chk("basic_done_once", 64'(dones), 64'd1);
    tick;

    // wrap and buffer 1
    words = 0;
    cmd(8'hFE, 4, 1);
    chk("wrap_buf_sel", 64'(acc_buf_sel), 64'd1);
    chk("wrap_setup_no_read", 64'(acc_rd_en), 64'd0);
    tick;
    chk("wrap_first_addr", 64'(acc_rd_addr), 64'hFE);
    tick;
    chk("wrap_first_word", out_data, 64'hB000_00FE_B000_00FE);
    wait_idle(50);
    chk("wrap_words", 64'(words), 64'd4);
    chk("wrap_sel_held", 64'(acc_buf_sel), 64'd1);
    tick;

    // backpressure: ten stalled cycles from the start cycle
    out_ready = 0;
    words = 0;
    reads = 0;
    cmd(8'h20, 8, 0);
    repeat (9) tick;
    chk("bp_reads", 64'(reads), 64'd4);
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_head", out_data, 64'h0000_0020_0000_0020);
    out_ready = 1;
    wait_idle(60);
    chk("bp_words", 64'(words), 64'd8);

    // zero-length command
    tick;
    dones = 0;
    reads = 0;
    cmd(8'h55, 0, 1);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd1);
    chk("zero_sel", 64'(acc_buf_sel), 64'd1);
    tick;
    chk("zero_done_off", 64'(done), 64'd0);
    chk("zero_busy_off", 64'(busy), 64'd0);
    chk("zero_no_reads", 64'(reads), 64'd0);
    chk("zero_done_once", 64'(dones), 64'd1);

    // full 256-word buffer from the middle
    words = 0;
    dones = 0;
    cmd(8'h80, 256, 0);
    wait_idle(400);
    chk("full_words", 64'(words), 64'd256);
    chk("full_done_once", 64'(dones), 64'd1);
    tick;

    // ignored start while busy, then abort mid-issue
    dones = 0;
    cmd(8'h30, 16, 1);
    repeat (3) tick;
    base_addr = 8'h40;
    count = 9'd2;
    buf_sel = 0;
    start = 1;
    tick;
    start = 0;
    tick;
    chk("ignored_start_sel", 64'(acc_buf_sel), 64'd1);
    tick;
    abort = 1;
    tick;
    abort = 0;
    clear_model();
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rd_en", 64'(acc_rd_en), 64'd0);
    tick;
    chk("abort_stale_dropped", 64'(out_valid), 64'd0);
    repeat (4) tick;
    chk("abort_no_done", 64'(dones), 64'd0);
    words = 0;
    cmd(8'h05, 3, 0);
    wait_idle(50);
    chk("post_abort_words", 64'(words), 64'd3);
    chk("post_abort_done", 64'(dones), 64'd1);
    tick;

    // reset while flushing
    out_ready = 0;
    cmd(8'h60, 3, 0);
    repeat (5) tick;
    chk("flush_busy", 64'(busy), 64'd1);
    chk("flush_valid", 64'(out_valid), 64'd1);
    rst_n = 0;
    #1;
    chk_reset_outputs("midrst");
    clear_model();
    tick;
    rst_n = 1;
    out_ready = 1;
    reads = 0;
    words = 0;
    repeat (5) tick;
    chk("postrst_reads", 64'(reads), 64'd0);
    chk("postrst_words", 64'(words), 64'd0);
    chk("postrst_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
